arbitro_escrita_registradores: RTL and testbench
================================================

# arbitro_escrita_registradores

Round-robin arbiter and write scheduler for the single write port of the 32×32-bit register file. It accepts write-back requests from up to `NUM_REQ` producers (ALU, load unit, multiplier, …), serialises them onto `regWrite`/`RD`/`dadosEscrita` with one registered stage, and keeps a per-register pending-write scoreboard. The issue stage uses the scoreboard to stall reads of registers with an outstanding write. It sits between the execute/memory units and the register file.

## Interface
- `NUM_REQ`, 3: number of write requesters (2..8).
- `clock` input 1: system clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `req_valid` input NUM_REQ: requester i holds a write request.
- `req_ready` output NUM_REQ: requester i's request is accepted this cycle.
- `req_rd` input 5·NUM_REQ: destination register; requester i uses bits [5i+4:5i].
- `req_dados` input 32·NUM_REQ: write data; requester i uses bits [32i+31:32i].
- `reserva_valid` input 1: issue stage reserves a destination register.
- `reserva_rd` input 5: register being reserved.
- `regWrite` output 1: write enable to the register file.
- `RD` output 5: write address to the register file.
- `dadosEscrita` output 32: write data to the register file.
- `pendente` output 32: bit r set while register r has an outstanding write.

## Operation
- Arbitration is combinational within the cycle. Search `req_valid` starting at the round-robin pointer `ptr`, wrapping at NUM_REQ. The first valid index found is granted.
- `req_ready` is one-hot or zero. Only a requester with `req_valid`=1 can be granted.
- A handshake occurs when `req_valid[i] && req_ready[i]`. At that clock edge:
  - the output registers load `regWrite`=1, `RD`=req_rd[i], `dadosEscrita`=req_dados[i];
  - `ptr` becomes (i+1) mod NUM_REQ.
- With no handshake, `regWrite` loads 0, and `RD`, `dadosEscrita` and `ptr` hold.
- The register file never backpressures. A grant is possible every cycle, giving a throughput of 1 write/cycle.
- Requesters must hold `req_valid`, `req_rd` and `req_dados` stable until accepted.
- Scoreboard, updated at each rising edge:
  - set: `reserva_valid` sets bit `reserva_rd`;
  - clear: `regWrite`=1 clears bit `RD`, on the same edge at which the register file captures the data.
  - When set and clear hit the same register on the same edge, the set wins and the bit stays 1.
  - Set and clear on different registers both take effect.
- A write to a register whose bit is already 0 is legal and leaves the bit at 0.

## Timing
- Reset, asynchronous on `reset_n`=0: `regWrite`=0, `RD`=0, `dadosEscrita`=0, `pendente`=0, `ptr`=0. `req_ready` is 0 while in reset.
- Reset asserted mid-operation discards any registered write in flight; no write reaches the register file.
- Latency from handshake edge:
  - `regWrite` is high for the cycle that follows;
  - the register file holds the data one edge later;
  - the `pendente` bit falls on that same edge.
- Reading a register with `pendente`=0 always returns the latest accepted write.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles.

## Configuration
- `ARB_ZERO_REG_EN`:
  - Defined: register 0 is hardwired zero.
    - Requests with rd=0 still complete the handshake, but the output stage loads `regWrite`=0.
    - `reserva_rd`=0 never sets `pendente[0]`, so `pendente[0]` is always 0.
  - Undefined: register 0 is ordinary; writes and reservations to it behave like those to any other register.

## Test plan
- Reset, then all `req_valid`=0 → `regWrite`=0, `pendente`=0, `req_ready`=0 every cycle.
- Single requester: req 1 writes rd=5, data=0xDEADBEEF → `req_ready`=3'b010 that cycle; next cycle `regWrite`=1, `RD`=5, `dadosEscrita`=0xDEADBEEF.
- NUM_REQ=3, all valid and held for 6 cycles from reset → grant order 0,1,2,0,1,2 with one write per cycle.
- Reserve rd=7, then write rd=7 three cycles later → `pendente[7]` is 1 from the edge after the reservation until the edge that ends the `regWrite` pulse.
  - Repeat with a new reservation of rd=7 on that same edge → `pendente[7]` stays 1.
- Assert `reset_n`=0 the cycle after a handshake → `regWrite` drops to 0 immediately and `pendente`=0.
- With `ARB_ZERO_REG_EN` defined: request rd=0, data=0x1 → handshake completes, `regWrite` stays 0. Reserve rd=0 → `pendente[0]` stays 0.

Source files
------------

// File: rtl/arbitro_escrita_registradores.sv
// Round-robin write-back arbiter for the register file's single write port, with a pending-write scoreboard.
// Optional build macro: ARB_ZERO_REG_EN (register 0 hardwired to zero).
module arbitro_escrita_registradores #(
    parameter int NUM_REQ = 3
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [5*NUM_REQ-1:0]   req_rd,
    input  logic [32*NUM_REQ-1:0]  req_dados,
    input  logic                   reserva_valid,
    input  logic [4:0]             reserva_rd,
    output logic                   regWrite,
    output logic [4:0]             RD,
    output logic [31:0]            dadosEscrita,
    output logic [31:0]            pendente
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef ARB_ZERO_REG_EN
    localparam logic ZERO_REG = 1'b1;
`else
    localparam logic ZERO_REG = 1'b0;
`endif

    logic [PW-1:0]          ptr_q, ptr_d;
    logic                   regwrite_q, regwrite_d;
    logic [4:0]             rd_q, rd_d;
    logic [31:0]            dados_q, dados_d;
    logic [31:0]            pend_q, pend_d;

    logic [2*NUM_REQ-1:0]   valid_dbl;
    logic [NUM_REQ-1:0]     valid_rot;
    logic [NUM_REQ-1:0]     first_rot;
    logic [2*NUM_REQ-1:0]   grant_dbl;
    logic [NUM_REQ-1:0]     grant;
    logic                   found;
    logic [4:0]             sel_rd;
    logic [31:0]            sel_dados;

    // Rotate requests so the pointer sits at bit 0, pick the lowest set bit, rotate back.
    always_comb begin
        valid_dbl = {req_valid, req_valid} >> ptr_q;
        valid_rot = valid_dbl[NUM_REQ-1:0];
        first_rot = '0;
        found     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && valid_rot[k]) begin
                first_rot[k] = 1'b1;
                found        = 1'b1;
            end
        end
        grant_dbl = {{NUM_REQ{1'b0}}, first_rot} << ptr_q;
        grant     = grant_dbl[NUM_REQ-1:0] | grant_dbl[2*NUM_REQ-1:NUM_REQ];
        if (!reset_n) begin
            grant = '0;
            found = 1'b0;
        end
    end

    assign req_ready = grant;

    always_comb begin
        sel_rd    = '0;
        sel_dados = '0;
        ptr_d     = ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_rd    = req_rd[5*i +: 5];
                sel_dados = req_dados[32*i +: 32];
                ptr_d     = (i == NUM_REQ - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    always_comb begin
        regwrite_d = 1'b0;
        rd_d       = rd_q;
        dados_d    = dados_q;
        if (found) begin
            // A handshake on register 0 is still consumed when it is hardwired; it just never writes.
            regwrite_d = !(ZERO_REG && (sel_rd == 5'd0));
            rd_d       = sel_rd;
            dados_d    = sel_dados;
        end
    end

    // Clear first so a same-edge reservation of the same register wins.
    always_comb begin
        pend_d = pend_q;
        if (regwrite_q) begin
            pend_d[rd_q] = 1'b0;
        end
        if (reserva_valid && !(ZERO_REG && (reserva_rd == 5'd0))) begin
            pend_d[reserva_rd] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q      <= '0;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            dados_q    <= '0;
            pend_q     <= '0;
        end else begin
            ptr_q      <= ptr_d;
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            dados_q    <= dados_d;
            pend_q     <= pend_d;
        end
    end

    assign regWrite     = regwrite_q;
    assign RD           = rd_q;
    assign dadosEscrita = dados_q;
    assign pendente     = pend_q;

endmodule

// File: tb/tb_arbitro_escrita_registradores.sv
// Directed bench for arbitro_escrita_registradores (NUM_REQ=3); expectations are hand-computed constants.
module tb_arbitro_escrita_registradores;

    localparam int N = 3;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [5*N-1:0]  req_rd = '0;
    logic [32*N-1:0] req_dados = '0;
    logic            reserva_valid = 1'b0;
    logic [4:0]      reserva_rd = '0;
    logic            regWrite;
    logic [4:0]      RD;
    logic [31:0]     dadosEscrita;
    logic [31:0]     pendente;

    int checks = 0;
    int failures = 0;

    arbitro_escrita_registradores #(.NUM_REQ(N)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_rd        (req_rd),
        .req_dados     (req_dados),
        .reserva_valid (reserva_valid),
        .reserva_rd    (reserva_rd),
        .regWrite      (regWrite),
        .RD            (RD),
        .dadosEscrita  (dadosEscrita),
        .pendente      (pendente)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] rd, input logic [31:0] d);
        req_rd[5*i +: 5]     = rd;
        req_dados[32*i +: 32] = d;
    endtask

    initial begin
        // Reset: outputs cleared, ready suppressed even with valid requests.
        req_valid = 3'b111;
        #12;
        chk("rst_regWrite", {31'd0, regWrite}, 32'd0);
        chk("rst_RD", {27'd0, RD}, 32'd0);
        chk("rst_dados", dadosEscrita, 32'd0);
        chk("rst_pendente", pendente, 32'd0);
        chk("rst_ready", {29'd0, req_ready}, 32'd0);
        req_valid = '0;
        tick();
        reset_n = 1'b1;

        for (int c = 0; c < 3; c++) begin
            tick();
            chk("idle_regWrite", {31'd0, regWrite}, 32'd0);
            chk("idle_pendente", pendente, 32'd0);
            chk("idle_ready", {29'd0, req_ready}, 32'd0);
        end

        // Single requester 1.
        set_req(1, 5'd5, 32'hDEADBEEF);
        req_valid = 3'b010;
        #1;
        chk("single_ready", {29'd0, req_ready}, 32'h2);
        tick();
        req_valid = '0;
        chk("single_regWrite", {31'd0, regWrite}, 32'd1);
        chk("single_RD", {27'd0, RD}, 32'd5);
        chk("single_dados", dadosEscrita, 32'hDEADBEEF);
        tick();
        chk("single_drop", {31'd0, regWrite}, 32'd0);
        chk("single_RD_hold", {27'd0, RD}, 32'd5);
        chk("single_dados_hold", dadosEscrita, 32'hDEADBEEF);

        // Fresh reset, then all three requesters held valid for six cycles.
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 5'(10 + i), 32'h100 + i);
        req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("rr_ready", {29'd0, req_ready}, 32'd1 << (c % 3));
            tick();
            chk("rr_regWrite", {31'd0, regWrite}, 32'd1);
            chk("rr_RD", {27'd0, RD}, 32'd10 + (c % 3));
            chk("rr_dados", dadosEscrita, 32'h100 + (c % 3));
        end
        req_valid = '0;
        tick();

        // Scoreboard: reserve r7, write r7 three edges later.
        reserva_valid = 1'b1;
        reserva_rd = 5'd7;
        tick();
        reserva_valid = 1'b0;
        chk("sb_set", pendente, 32'h80);
        tick();
        chk("sb_hold", pendente, 32'h80);
        set_req(0, 5'd7, 32'h77);
        req_valid = 3'b001;
        #1;
        chk("sb_ready", {29'd0, req_ready}, 32'h1);
        tick();
        req_valid = '0;
        chk("sb_wr_regWrite", {31'd0, regWrite}, 32'd1);
        chk("sb_wr_pend", pendente, 32'h80);
        tick();
        chk("sb_clear", pendente, 32'h0);
        chk("sb_clear_regWrite", {31'd0, regWrite}, 32'd0);

        // Same-register set and clear on one edge: set wins.
        reserva_valid = 1'b1;
        reserva_rd = 5'd7;
        tick();
        reserva_valid = 1'b0;
        set_req(0, 5'd7, 32'h78);
        req_valid = 3'b001;
        tick();
        req_valid = '0;
        reserva_valid = 1'b1;
        reserva_rd = 5'd7;
        chk("sb2_regWrite", {31'd0, regWrite}, 32'd1);
        tick();
        reserva_valid = 1'b0;
        chk("sb2_setwins", pendente, 32'h80);

        // Different registers on one edge: both take effect.
        set_req(0, 5'd7, 32'h79);
        req_valid = 3'b001;
        tick();
        req_valid = '0;
        reserva_valid = 1'b1;
        reserva_rd = 5'd3;
        tick();
        reserva_valid = 1'b0;
        chk("sb3_both", pendente, 32'h08);

        // Write to a register with no pending bit leaves scoreboard unchanged.
        set_req(0, 5'd12, 32'h5);
        req_valid = 3'b001;
        tick();
        req_valid = '0;
        tick();
        chk("sb4_nopend", pendente, 32'h08);

        // Pointer is now 1: valid {2,0} must grant 2.
        req_valid = 3'b101;
        #1;
        chk("rr_skip", {29'd0, req_ready}, 32'h4);
        req_valid = '0;

        // Reset right after a handshake discards the in-flight write.
        tick();
        set_req(2, 5'd20, 32'hABC);
        req_valid = 3'b100;
        tick();
        req_valid = '0;
        chk("mid_regWrite_pre", {31'd0, regWrite}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_regWrite", {31'd0, regWrite}, 32'd0);
        chk("mid_pendente", pendente, 32'd0);
        chk("mid_RD", {27'd0, RD}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("mid_after", {31'd0, regWrite}, 32'd0);

        // Register 0 behaviour.
        set_req(0, 5'd0, 32'h1);
        req_valid = 3'b001;
        #1;
        chk("zr_ready", {29'd0, req_ready}, 32'h1);
        tick();
        req_valid = '0;
`ifdef ARB_ZERO_REG_EN
        chk("zr_regWrite", {31'd0, regWrite}, 32'd0);
`else
        chk("zr_regWrite", {31'd0, regWrite}, 32'd1);
        chk("zr_dados", dadosEscrita, 32'h1);
`endif
        tick();
        reserva_valid = 1'b1;
        reserva_rd = 5'd0;
        tick();
        reserva_valid = 1'b0;
`ifdef ARB_ZERO_REG_EN
        chk("zr_pend", pendente, 32'h0);
`else
        chk("zr_pend", pendente, 32'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
